// File: rtl/reset_sequencer.sv
// Ordered per-stage reset release with software reset and reset-cause reporting.
// Optional watchdog is enabled by defining RST_SEQ_WDT_EN (adds the wdt_kick port).
module reset_sequencer #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned STAGE_GAP   = 4,
   parameter int unsigned NUM_STAGES  = 3,
   parameter int unsigned WDT_CYCLES  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sw_rst_req,
   output logic                  sw_rst_ack,
   output logic [NUM_STAGES-1:0] stage_rst,
   output logic                  rst_done,
   output logic                  seq_busy,
   output logic [1:0]            rst_cause
`ifdef RST_SEQ_WDT_EN
   ,
   input  logic                  wdt_kick
`endif
);

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

   localparam logic [1:0] ST_HOLD    = 2'd0;
   localparam logic [1:0] ST_RELEASE = 2'd1;
   localparam logic [1:0] ST_RUN     = 2'd2;

   localparam logic [1:0] CAUSE_COLD = 2'b01;
   localparam logic [1:0] CAUSE_SW   = 2'b10;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  ack_q, ack_d;
   logic [1:0]            cause_q, cause_d;
   logic                  wdt_fire;

`ifdef RST_SEQ_WDT_EN
   localparam int unsigned     WW        = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   localparam logic [WW-1:0]   WDT_LAST  = WW'(WDT_CYCLES - 1);
   localparam logic [1:0]      CAUSE_WDT = 2'b11;

   logic [WW-1:0] wdt_q, wdt_d;

   // A kick on the timeout cycle wins, so a pending software request still proceeds.
   assign wdt_fire = (state_q == ST_RUN) && !wdt_kick && (wdt_q == WDT_LAST);

   always_comb begin
      wdt_d = '0;
      if ((state_q == ST_RUN) && !wdt_kick && !wdt_fire && !sw_rst_req)
         wdt_d = wdt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) wdt_q <= '0;
      else     wdt_q <= wdt_d;
   end
`else
   assign wdt_fire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      stage_d = stage_q;
      done_d  = done_q;
      busy_d  = busy_q;
      ack_d   = 1'b0;
      cause_d = cause_q;
      case (state_q)
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               stage_d = stage_q << 1;
               if (NUM_STAGES == 1) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_RELEASE;
                  idx_d   = IW'(1);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               stage_d = stage_q << 1;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (wdt_fire || sw_rst_req) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               idx_d   = '0;
               stage_d = '1;
               done_d  = 1'b0;
               busy_d  = 1'b1;
               cause_d = CAUSE_SW;
               ack_d   = 1'b1;
`ifdef RST_SEQ_WDT_EN
               if (wdt_fire) begin
                  cause_d = CAUSE_WDT;
                  ack_d   = 1'b0;
               end
`endif
            end
         end
         default: begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            stage_d = '1;
            done_d  = 1'b0;
            busy_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         stage_q <= '1;
         done_q  <= 1'b0;
         busy_q  <= 1'b1;
         ack_q   <= 1'b0;
         cause_q <= CAUSE_COLD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stage_q <= stage_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         cause_q <= cause_d;
      end
   end

   always_ff @(posedge clk) begin
      assert (HOLD_CYCLES >= 1 && STAGE_GAP >= 1 && NUM_STAGES >= 1 && WDT_CYCLES >= 1);
   end

   assign stage_rst  = stage_q;
   assign rst_done   = done_q;
   assign seq_busy   = busy_q;
   assign sw_rst_ack = ack_q;
   assign rst_cause  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised self-checking bench for reset_sequencer against a timeline model.
// Watchdog scenarios are included when RST_SEQ_WDT_EN is defined.
module tb_reset_sequencer;

   localparam int HOLD   = 16;
   localparam int GAP    = 4;
   localparam int NS     = 3;
   localparam int LAST_T = HOLD + (NS - 1) * GAP;
`ifdef RST_SEQ_WDT_EN
   localparam int WDT    = 8;
   localparam bit WDT_ON = 1'b1;
`else
   localparam int WDT    = 1024;
   localparam bit WDT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sw_rst_req = 1'b0;
   logic          sw_rst_ack;
   logic [NS-1:0] stage_rst;
   logic          rst_done;
   logic          seq_busy;
   logic [1:0]    rst_cause;
`ifdef RST_SEQ_WDT_EN
   logic          wdt_kick = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Model: edges since the last reset event, last cause, ack pulse, idle RUN cycles.
   int       m_t = 0;
   logic [1:0] m_cause = 2'b00;
   logic     m_ack = 1'b0;
   int       m_idle = 0;

   reset_sequencer #(
      .HOLD_CYCLES (HOLD),
      .STAGE_GAP   (GAP),
      .NUM_STAGES  (NS),
      .WDT_CYCLES  (WDT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_rst_req (sw_rst_req),
      .sw_rst_ack (sw_rst_ack),
      .stage_rst  (stage_rst),
      .rst_done   (rst_done),
      .seq_busy   (seq_busy),
      .rst_cause  (rst_cause)
`ifdef RST_SEQ_WDT_EN
      ,
      .wdt_kick   (wdt_kick)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_edge(input logic r, input logic s, input logic k);
      bit in_run;
      in_run = (m_t >= LAST_T);
      m_ack  = 1'b0;
      if (r) begin
         m_t = 0; m_cause = 2'b01; m_idle = 0;
      end else if (WDT_ON && in_run && !k && m_idle == WDT - 1) begin
         m_t = 0; m_cause = 2'b11; m_idle = 0;
      end else if (in_run && s) begin
         m_t = 0; m_cause = 2'b10; m_ack = 1'b1; m_idle = 0;
      end else begin
         if (m_t < LAST_T) m_t++;
         if (in_run && !k) m_idle++;
         else m_idle = 0;
      end
   endtask

   task automatic cycle(input logic r, input logic s, input logic k);
      rst = r;
      sw_rst_req = s;
`ifdef RST_SEQ_WDT_EN
      wdt_kick = k;
`endif
      @(posedge clk);
      model_edge(r, s, k);
      #1;
   endtask

   function automatic logic [NS+4:0] exp_vec();
      logic [NS-1:0] st;
      for (int k = 0; k < NS; k++) st[k] = (m_t < HOLD + k * GAP);
      return {st, (m_t >= LAST_T), (m_t < LAST_T), m_ack, m_cause};
   endfunction

   function automatic logic [NS+4:0] got_vec();
      return {stage_rst, rst_done, seq_busy, sw_rst_ack, rst_cause};
   endfunction

   task automatic test_reset();
      logic [NS-1:0] want;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         n_checks++;
         if (stage_rst !== 3'b111 || rst_cause !== 2'b01 || rst_done !== 1'b0 || seq_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold cyc=%0d got stage=%b cause=%b done=%b busy=%b exp stage=111 cause=01 done=0 busy=1",
                     i, stage_rst, rst_cause, rst_done, seq_busy);
         end
      end
      for (int e = 1; e <= 30; e++) begin
         cycle(1'b0, 1'b0, 1'b0);
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_model edge=%0d got=%b exp=%b", e, got_vec(), exp_vec());
         end
         if (e == 15 || e == 16 || e == 20 || e == 24) begin
            want = (e == 15) ? 3'b111 : (e == 16) ? 3'b110 : (e == 20) ? 3'b100 : 3'b000;
            n_checks++;
            if (stage_rst !== want || rst_done !== (e == 24) || sw_rst_ack !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_timing edge=%0d got stage=%b done=%b ack=%b exp stage=%b done=%b ack=0",
                        e, stage_rst, rst_done, sw_rst_ack, want, (e == 24));
            end
         end
      end
   endtask

   task automatic test_sw_reset();
      int  waited = 0;
      bit  seen   = 1'b0;
      logic [NS-1:0] want;
      while (!seen && waited < 8) begin
         cycle(1'b0, 1'b1, 1'b0);
         waited++;
         seen = (sw_rst_ack === 1'b1);
      end
      n_checks++;
      if (!seen || waited != 1 || stage_rst !== 3'b111 || rst_done !== 1'b0 || rst_cause !== 2'b10) begin
         n_fail++;
         $display("FAIL sw_ack got seen=%0d wait=%0d stage=%b done=%b cause=%b exp seen=1 wait=1 stage=111 done=0 cause=10",
                  seen, waited, stage_rst, rst_done, rst_cause);
      end
      for (int e = 1; e <= 26; e++) begin
         cycle(1'b0, 1'b0, 1'b0);
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL sw_model edge=%0d got=%b exp=%b", e, got_vec(), exp_vec());
         end
         if (e == 1 || e == 16 || e == 20 || e == 24) begin
            want = (e == 1) ? 3'b111 : (e == 16) ? 3'b110 : (e == 20) ? 3'b100 : 3'b000;
            n_checks++;
            if (stage_rst !== want || sw_rst_ack !== 1'b0 || rst_cause !== 2'b10) begin
               n_fail++;
               $display("FAIL sw_timing edge=%0d got stage=%b ack=%b cause=%b exp stage=%b ack=0 cause=10",
                        e, stage_rst, sw_rst_ack, rst_cause, want);
            end
         end
      end
   endtask

   task automatic test_req_during_seq();
      logic s;
      cycle(1'b1, 1'b0, 1'b0);
      for (int e = 1; e <= 52; e++) begin
         s = (e >= 5 && e <= 30);
         cycle(1'b0, s, 1'b0);
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL req_seq_model edge=%0d got=%b exp=%b", e, got_vec(), exp_vec());
         end
         if (e == 24 || e == 25 || e == 48 || e == 49) begin
            n_checks++;
            if (sw_rst_ack !== (e == 25) || rst_done !== (e == 24 || e == 49)) begin
               n_fail++;
               $display("FAIL req_seq_timing edge=%0d got ack=%b done=%b exp ack=%b done=%b",
                        e, sw_rst_ack, rst_done, (e == 25), (e == 24 || e == 49));
            end
         end
      end
   endtask

   task automatic test_rst_mid();
      cycle(1'b1, 1'b0, 1'b0);
      for (int e = 1; e <= 18 + 26; e++) begin
         cycle((e == 18), 1'b0, 1'b0);
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rst_mid_model edge=%0d got=%b exp=%b", e, got_vec(), exp_vec());
         end
         if (e == 17 || e == 18 || e == 18 + 16) begin
            n_checks++;
            if (stage_rst !== ((e == 18) ? 3'b111 : 3'b110) || rst_cause !== 2'b01) begin
               n_fail++;
               $display("FAIL rst_mid_timing edge=%0d got stage=%b cause=%b exp stage=%b cause=01",
                        e, stage_rst, rst_cause, ((e == 18) ? 3'b111 : 3'b110));
            end
         end
      end
   endtask

   task automatic test_coincident();
      cycle(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (rst_cause !== 2'b01 || sw_rst_ack !== 1'b0 || stage_rst !== 3'b111 || got_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL coincident got cause=%b ack=%b stage=%b exp cause=01 ack=0 stage=111",
                  rst_cause, sw_rst_ack, stage_rst);
      end
      for (int e = 1; e <= 26; e++) cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (got_vec() !== exp_vec() || rst_done !== 1'b1) begin
         n_fail++;
         $display("FAIL coincident_recover got=%b exp=%b", got_vec(), exp_vec());
      end
   endtask

`ifdef RST_SEQ_WDT_EN
   task automatic test_watchdog();
      cycle(1'b1, 1'b0, 1'b0);
      for (int e = 1; e <= LAST_T + WDT + 2; e++) begin
         cycle(1'b0, 1'b0, 1'b0);
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL wdt_model edge=%0d got=%b exp=%b", e, got_vec(), exp_vec());
         end
         if (e == LAST_T + WDT - 1 || e == LAST_T + WDT) begin
            n_checks++;
            if (rst_cause !== ((e == LAST_T + WDT) ? 2'b11 : 2'b01) || sw_rst_ack !== 1'b0 ||
                rst_done !== (e != LAST_T + WDT)) begin
               n_fail++;
               $display("FAIL wdt_timeout edge=%0d got cause=%b ack=%b done=%b", e, rst_cause, sw_rst_ack, rst_done);
            end
         end
      end
      cycle(1'b1, 1'b0, 1'b0);
      for (int e = 1; e <= LAST_T + 100; e++) begin
         cycle(1'b0, 1'b0, (e % 5 == 0));
         n_checks++;
         if (got_vec() !== exp_vec() || (e >= LAST_T && (rst_done !== 1'b1 || rst_cause !== 2'b01))) begin
            n_fail++;
            $display("FAIL wdt_kicked edge=%0d got=%b exp=%b", e, got_vec(), exp_vec());
         end
      end
   endtask
`endif

   task automatic test_random();
      logic r, s, k;
      int   hold_s = 0;
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 249) == 0);
         if (hold_s > 0) begin
            s = 1'b1;
            hold_s--;
         end else begin
            s = 1'b0;
            if ($urandom_range(0, 39) == 0) hold_s = $urandom_range(1, 30);
         end
         k = ($urandom_range(0, 5) == 0);
         cycle(r, s, k);
         n_checks++;
         if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cyc=%0d r=%b s=%b k=%b got=%b exp=%b", i, r, s, k, got_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw_reset();
      test_req_during_seq();
      test_rst_mid();
      test_coincident();
`ifdef RST_SEQ_WDT_EN
      test_watchdog();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
